// File: rtl/divider_pkg.sv
// Shared state encoding and default width for the sequential divider.
package divider_pkg;
    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/sub_8b.sv
// W-bit combinational subtractor with borrow-in and borrow-out.
module sub_8b
    import divider_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         borrow_in,
    output logic [W-1:0] diff,
    output logic         borrow_out
);
    assign {borrow_out, diff} = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, borrow_in};
endmodule

// File: rtl/seq_divider_8b.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
//   state | meaning
//   IDLE  | waiting for START
//   CALC  | W trial-subtraction iterations in progress
//   FIN   | result valid, DONE high; START here begins the next operation
module seq_divider_8b
    import divider_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         BUSY,
    output logic         DONE,
    output logic         DIV0
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  rp;
    logic [CW-1:0] cnt;

    logic [W:0]    t;
    logic [W-1:0]  diff;
    logic          borrow;
    logic          qbit;
    logic [W-1:0]  rp_next;

    // T keeps the remainder MSB so divisors with their top bit set still divide correctly;
    // when T[W] is set, T >= B and the low W bits of the subtractor hold T - B.
    assign t = {rp, a_sh[W-1]};

    sub_8b #(.W(W)) u_sub (
        .x          (t[W-1:0]),
        .y          (b_reg),
        .borrow_in  (1'b0),
        .diff       (diff),
        .borrow_out (borrow)
    );

    assign qbit    = t[W] | ~borrow;
    assign rp_next = qbit ? diff : t[W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a_sh  <= '0;
            b_reg <= '0;
            rp    <= '0;
            cnt   <= '0;
            Q     <= '0;
            R     <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            DIV0  <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (START) begin
                        a_sh  <= A;
                        b_reg <= B;
                        rp    <= '0;
                        cnt   <= CNT_LOAD;
                        if (B == '0) begin
                            state <= FIN;
                            Q     <= '1;
                            R     <= A;
                            DIV0  <= 1'b1;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= CALC;
                            DIV0  <= 1'b0;
                            BUSY  <= 1'b1;
                            DONE  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b0;
                    end
                end
                CALC: begin
                    // Quotient bits shift into the dividend register as its bits are consumed.
                    a_sh <= {a_sh[W-2:0], qbit};
                    rp   <= rp_next;
                    if (cnt == '0) begin
                        state <= FIN;
                        Q     <= {a_sh[W-2:0], qbit};
                        R     <= rp_next;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_8b.sv
// Self-checking bench for seq_divider_8b against an arithmetic reference model.
module tb_seq_divider_8b;
    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Q, R;
    logic         BUSY, DONE, DIV0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider_8b #(.W(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .Q(Q), .R(R), .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0)
    );

    always #5 CLK = ~CLK;

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? MAXV : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Issues one single-cycle START and waits for DONE; lat counts edges after the accepting edge.
    task automatic run_op(input int a, input int b, output int lat, output int busy_cnt,
                          output int tmo);
        @(negedge CLK);
        A = W'(a); B = W'(b); START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        lat = 0; busy_cnt = 0; tmo = 0;
        while (!DONE) begin
            if (BUSY) busy_cnt++;
            lat++;
            if (lat > 40) begin
                tmo = 1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({Q, R, BUSY, DONE, DIV0} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: Q=%0d R=%0d BUSY=%b DONE=%b DIV0=%b, required all 0",
                     Q, R, BUSY, DONE, DIV0);
        end
        RST = 1'b0;
    endtask

    task automatic test_directed();
        int lat, bc, tmo;
        int av[5] = '{100, 255, 5, 255, 0};
        int bv[5] = '{7, 1, 9, 200, 3};
        for (int i = 0; i < 5; i++) begin
            run_op(av[i], bv[i], lat, bc, tmo);
            n_checks++;
            if (tmo != 0 || lat != W || bc != W) begin
                n_fail++;
                $display("FAIL directed_timing %0d/%0d: latency=%0d busy=%0d timeout=%0d, required %0d/%0d/0",
                         av[i], bv[i], lat, bc, tmo, W, W);
            end
            n_checks++;
            if (Q !== W'(ref_q(av[i], bv[i])) || R !== W'(ref_r(av[i], bv[i])) || DIV0 !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_result %0d/%0d: Q=%0d R=%0d DIV0=%b, required Q=%0d R=%0d DIV0=0",
                         av[i], bv[i], Q, R, DIV0, ref_q(av[i], bv[i]), ref_r(av[i], bv[i]));
            end
        end
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0 || Q !== W'(ref_q(0, 3))) begin
            n_fail++;
            $display("FAIL done_pulse_hold: DONE=%b Q=%0d, required DONE=0 Q=%0d", DONE, Q, ref_q(0, 3));
        end
    endtask

    task automatic test_div0();
        int lat, bc, tmo;
        run_op(37, 0, lat, bc, tmo);
        n_checks++;
        if (tmo != 0 || lat != 0 || bc != 0) begin
            n_fail++;
            $display("FAIL div0_timing: latency=%0d busy=%0d timeout=%0d, required 0/0/0", lat, bc, tmo);
        end
        n_checks++;
        if (Q !== 8'd255 || R !== 8'd37 || DIV0 !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_result: Q=%0d R=%0d DIV0=%b BUSY=%b, required 255/37/1/0", Q, R, DIV0, BUSY);
        end
        run_op(20, 3, lat, bc, tmo);
        n_checks++;
        if (DIV0 !== 1'b0 || Q !== 8'd6 || R !== 8'd2) begin
            n_fail++;
            $display("FAIL div0_clear: Q=%0d R=%0d DIV0=%b, required 6/2/0", Q, R, DIV0);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0, first = -1;
        @(negedge CLK);
        A = 8'd200; B = 8'd13; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int n = 0; n < 25; n++) begin
            if (n == 2) begin A = 8'd9; B = 8'd2; START = 1'b1; end
            if (n == 3) START = 1'b0;
            if (DONE) begin
                dones++;
                if (first < 0) begin
                    first = n;
                    n_checks++;
                    if (Q !== 8'd15 || R !== 8'd5) begin
                        n_fail++;
                        $display("FAIL ignore_start_result: Q=%0d R=%0d, required 15/5", Q, R);
                    end
                end
            end
            @(negedge CLK);
        end
        n_checks++;
        if (dones != 1 || first != W) begin
            n_fail++;
            $display("FAIL ignore_start_dones: count=%0d first=%0d, required 1 at %0d", dones, first, W);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0, lat, bc, tmo;
        @(negedge CLK);
        A = 8'd100; B = 8'd7; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({Q, R, BUSY, DONE, DIV0} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_state: Q=%0d R=%0d BUSY=%b DONE=%b DIV0=%b, required all 0",
                     Q, R, BUSY, DONE, DIV0);
        end
        RST = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (DONE || BUSY) dones++;
            @(negedge CLK);
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid_abandon: active cycles=%0d, required 0", dones);
        end
        run_op(50, 6, lat, bc, tmo);
        n_checks++;
        if (tmo != 0 || lat != W || Q !== 8'd8 || R !== 8'd2) begin
            n_fail++;
            $display("FAIL reset_mid_recover: latency=%0d Q=%0d R=%0d, required %0d/8/2", lat, Q, R, W);
        end
    endtask

    task automatic test_back_to_back();
        int t_done[$];
        @(negedge CLK);
        A = 8'd60; B = 8'd4; START = 1'b1;
        @(negedge CLK);
        for (int n = 0; n < 40 && t_done.size() < 2; n++) begin
            if (DONE) begin
                t_done.push_back(n);
                n_checks++;
                if (Q !== 8'd15 || R !== 8'd0) begin
                    n_fail++;
                    $display("FAIL b2b_result %0d: Q=%0d R=%0d, required 15/0", t_done.size(), Q, R);
                end
                if (t_done.size() == 2) START = 1'b0;
            end
            @(negedge CLK);
        end
        // Eight CALC cycles sit between the two DONE cycles.
        n_checks++;
        if (t_done.size() != 2 || t_done[1] - t_done[0] != W + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: pulses=%0d gap=%0d, required 2 pulses gap %0d",
                     t_done.size(), (t_done.size() == 2) ? t_done[1] - t_done[0] : -1, W + 1);
        end
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: DONE=%b BUSY=%b, required 0/0", DONE, BUSY);
        end
    endtask

    task automatic test_random();
        int a, b, lat, bc, tmo;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, MAXV));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAXV));
            run_op(a, b, lat, bc, tmo);
            n_checks++;
            if (tmo != 0 || lat != ((b == 0) ? 0 : W) || Q !== W'(ref_q(a, b)) ||
                R !== W'(ref_r(a, b)) || DIV0 !== (b == 0)) begin
                n_fail++;
                $display("FAIL random %0d/%0d: Q=%0d R=%0d DIV0=%b lat=%0d, required Q=%0d R=%0d DIV0=%0d lat=%0d",
                         a, b, Q, R, DIV0, lat, ref_q(a, b), ref_r(a, b), (b == 0), (b == 0) ? 0 : W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div0();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
